// File: rtl/mem_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// mem_arbiter_pkg : shared state, owner and constant definitions for mem_arbiter
// Rev 1.0
// ============================================================================
package mem_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    typedef enum logic {
        OWN_I = 1'b0,
        OWN_D = 1'b1
    } owner_t;

    localparam logic [3:0] C_FETCH_BE = 4'hF;

    // Counter must be able to hold the limit value itself (saturating count).
    function automatic int starve_cnt_w(input int limit);
        return (limit < 1) ? 1 : $clog2(limit + 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/mem_arbiter_if.sv
`default_nettype none
// ============================================================================
// mem_arbiter_if : fetch, data and shared-memory bus signals of mem_arbiter
// Rev 1.0
// ============================================================================
interface mem_arbiter_if;
    import mem_arbiter_pkg::*;

    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic        imem_valid;
    logic [31:0] imem_rdata;

    logic        dmem_req;
    logic        dmem_we;
    logic [3:0]  dmem_be;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic        dmem_ready;
    logic        dmem_valid;
    logic [31:0] dmem_rdata;

    logic        mem_req;
    logic        mem_we;
    logic [3:0]  mem_be;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_gnt;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;
    logic        mem_err;

    modport slave (
        input  imem_req, imem_addr,
        input  dmem_req, dmem_we, dmem_be, dmem_addr, dmem_wdata,
        input  mem_gnt, mem_rvalid, mem_rdata,
        output imem_ready, imem_valid, imem_rdata,
        output dmem_ready, dmem_valid, dmem_rdata,
        output mem_req, mem_we, mem_be, mem_addr, mem_wdata, mem_err
    );

    modport master (
        output imem_req, imem_addr,
        output dmem_req, dmem_we, dmem_be, dmem_addr, dmem_wdata,
        output mem_gnt, mem_rvalid, mem_rdata,
        input  imem_ready, imem_valid, imem_rdata,
        input  dmem_ready, dmem_valid, dmem_rdata,
        input  mem_req, mem_we, mem_be, mem_addr, mem_wdata, mem_err
    );

endinterface
`default_nettype wire

// File: rtl/mem_arb_pick.sv
`default_nettype none
// ============================================================================
// mem_arb_pick : data-priority grant with fetch anti-starvation counter update
// Rev 1.0
// ============================================================================
module mem_arb_pick
    import mem_arbiter_pkg::*;
#(
    parameter int STARVE_LIMIT = 4,
    parameter int CNT_W        = starve_cnt_w(STARVE_LIMIT)
) (
    input  wire              i_arb_en,
    input  wire              i_imem_req,
    input  wire              i_dmem_req,
    input  wire [CNT_W-1:0]  i_starve_cnt,
    output logic             o_grant_i,
    output logic             o_grant_d,
    output logic [CNT_W-1:0] o_starve_nxt
);

    localparam logic [CNT_W-1:0] C_LIMIT = CNT_W'(STARVE_LIMIT);

    logic w_starved;
    logic w_grant_i;
    logic w_grant_d;

    assign w_starved = (i_starve_cnt == C_LIMIT);
    assign w_grant_i = i_arb_en && i_imem_req && (!i_dmem_req || w_starved);
    assign w_grant_d = i_arb_en && i_dmem_req && !w_grant_i;

    assign o_grant_i = w_grant_i;
    assign o_grant_d = w_grant_d;

    // Counts data wins that bypassed a waiting fetch; any fetch win or idle fetch port clears it.
    always_comb begin
        o_starve_nxt = i_starve_cnt;
        if (!i_imem_req || w_grant_i) begin
            o_starve_nxt = '0;
        end else if (w_grant_d && !w_starved) begin
            o_starve_nxt = i_starve_cnt + CNT_W'(1);
        end
    end

endmodule
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// mem_arbiter : fetch/data port arbiter onto one single-outstanding memory bus
// Optional watchdog enabled by defining MEM_ARB_TIMEOUT_EN.   Rev 1.0
// ============================================================================
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int STARVE_LIMIT   = 4,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  wire          clk,
    input  wire          reset,
    mem_arbiter_if.slave bus
);

    localparam int CNT_W = starve_cnt_w(STARVE_LIMIT);

    if (STARVE_LIMIT < 1 || TIMEOUT_CYCLES < 1) begin : g_param_check
        $error("mem_arbiter: STARVE_LIMIT and TIMEOUT_CYCLES must be at least 1");
    end

    state_t           r_state;
    state_t           w_state_nxt;
    owner_t           r_owner;
    logic [31:0]      r_addr;
    logic [31:0]      r_wdata;
    logic             r_we;
    logic [3:0]       r_be;
    logic             r_imem_valid;
    logic             r_dmem_valid;
    logic [31:0]      r_imem_rdata;
    logic [31:0]      r_dmem_rdata;
    logic [CNT_W-1:0] r_starve;
    logic [CNT_W-1:0] w_starve_nxt;
    logic             w_arb_en;
    logic             w_grant_i;
    logic             w_grant_d;
    logic             w_rvalid_hit;
    logic             w_timeout;
    logic             w_complete;
    logic [31:0]      w_resp_data;

    assign w_arb_en = reset && (r_state == ST_IDLE);

    mem_arb_pick #(
        .STARVE_LIMIT (STARVE_LIMIT),
        .CNT_W        (CNT_W)
    ) u_pick (
        .i_arb_en     (w_arb_en),
        .i_imem_req   (bus.imem_req),
        .i_dmem_req   (bus.dmem_req),
        .i_starve_cnt (r_starve),
        .o_grant_i    (w_grant_i),
        .o_grant_d    (w_grant_d),
        .o_starve_nxt (w_starve_nxt)
    );

`ifdef MEM_ARB_TIMEOUT_EN
    localparam int WAIT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [WAIT_W-1:0] r_wait;
    logic              r_err;

    assign w_timeout = (r_state != ST_IDLE) && (r_wait == WAIT_W'(TIMEOUT_CYCLES - 1));

    // Restarts on every state change, so the limit applies separately to REQ and RESP.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_wait <= '0;
            r_err  <= 1'b0;
        end else begin
            if (w_state_nxt != r_state) begin
                r_wait <= '0;
            end else if (r_state != ST_IDLE) begin
                r_wait <= r_wait + WAIT_W'(1);
            end
            if (w_timeout) begin
                r_err <= 1'b1;
            end
        end
    end

    assign bus.mem_err = r_err;
`else
    assign w_timeout   = 1'b0;
    assign bus.mem_err = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_rvalid_hit   = 1'b0;
        bus.mem_req    = 1'b0;
        bus.imem_ready = w_grant_i;
        bus.dmem_ready = w_grant_d;
        unique case (r_state)
            ST_IDLE: begin
                if (w_grant_i || w_grant_d) begin
                    w_state_nxt = ST_REQ;
                end
            end
            ST_REQ: begin
                bus.mem_req = 1'b1;
                if (w_timeout) begin
                    w_state_nxt = ST_IDLE;
                end else if (bus.mem_gnt) begin
                    w_state_nxt = ST_RESP;
                end
            end
            ST_RESP: begin
                w_rvalid_hit = bus.mem_rvalid;
                if (bus.mem_rvalid || w_timeout) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    assign w_complete  = w_rvalid_hit || w_timeout;
    assign w_resp_data = w_rvalid_hit ? bus.mem_rdata : 32'h0;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_starve     <= '0;
            r_owner      <= OWN_I;
            r_addr       <= '0;
            r_we         <= 1'b0;
            r_be         <= '0;
            r_wdata      <= '0;
            r_imem_valid <= 1'b0;
            r_dmem_valid <= 1'b0;
            r_imem_rdata <= '0;
            r_dmem_rdata <= '0;
        end else begin
            r_starve     <= w_starve_nxt;
            r_imem_valid <= w_complete && (r_owner == OWN_I);
            r_dmem_valid <= w_complete && (r_owner == OWN_D);
            if (w_complete && (r_owner == OWN_I)) begin
                r_imem_rdata <= w_resp_data;
            end
            if (w_complete && (r_owner == OWN_D)) begin
                r_dmem_rdata <= w_resp_data;
            end
            if (w_grant_d) begin
                r_owner <= OWN_D;
                r_addr  <= bus.dmem_addr;
                r_we    <= bus.dmem_we;
                r_be    <= bus.dmem_be;
                r_wdata <= bus.dmem_wdata;
            end else if (w_grant_i) begin
                r_owner <= OWN_I;
                r_addr  <= bus.imem_addr;
                r_we    <= 1'b0;
                r_be    <= C_FETCH_BE;
                r_wdata <= '0;
            end
        end
    end

    assign bus.mem_we     = r_we;
    assign bus.mem_be     = r_be;
    assign bus.mem_addr   = r_addr;
    assign bus.mem_wdata  = r_wdata;
    assign bus.imem_valid = r_imem_valid;
    assign bus.imem_rdata = r_imem_rdata;
    assign bus.dmem_valid = r_dmem_valid;
    assign bus.dmem_rdata = r_dmem_rdata;

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
// tb_mem_arbiter : directed and randomized self-checking bench for mem_arbiter
// Rev 1.0
// ============================================================================
module tb_mem_arbiter;

    localparam int LIMIT = 4;
    localparam int TMO   = 8;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    int   checks = 0;
    int   errors = 0;

    mem_arbiter_if bus();

    mem_arbiter #(
        .STARVE_LIMIT   (LIMIT),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Reference model state for the randomized phase (transaction level).
    bit          m_busy, m_granted, m_own_d, m_exp_vi, m_exp_vd;
    bit          ip, dp, gi_prev, exp_gi, exp_gd;
    logic        m_we;
    logic [3:0]  m_be;
    logic [31:0] m_addr, m_wdata, m_exp_irdata, m_exp_drdata, daddr;
    int          m_starve, m_wait;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic simple_txn(input bit is_d, input logic [31:0] addr, input logic [31:0] data);
        cyc();
        if (is_d) begin
            bus.dmem_req = 1'b1; bus.dmem_addr = addr; bus.dmem_we = 1'b0; bus.dmem_be = 4'hF;
        end else begin
            bus.imem_req = 1'b1; bus.imem_addr = addr;
        end
        #2;
        check("txn_ready", is_d ? bus.dmem_ready : bus.imem_ready, 32'd1);
        cyc(); bus.imem_req = 1'b0; bus.dmem_req = 1'b0; bus.mem_gnt = 1'b1; #2;
        check("txn_addr", bus.mem_addr, addr);
        cyc(); bus.mem_gnt = 1'b0; bus.mem_rvalid = 1'b1; bus.mem_rdata = data;
        cyc(); bus.mem_rvalid = 1'b0; #2;
        check("txn_valid", is_d ? bus.dmem_valid : bus.imem_valid, 32'd1);
        check("txn_rdata", is_d ? bus.dmem_rdata : bus.imem_rdata, data);
    endtask

    initial begin
        bus.imem_req = 1'b1; bus.imem_addr = 32'h0;
        bus.dmem_req = 1'b1; bus.dmem_we = 1'b0; bus.dmem_be = 4'h0;
        bus.dmem_addr = 32'h0; bus.dmem_wdata = 32'h0;
        bus.mem_gnt = 1'b0; bus.mem_rvalid = 1'b0; bus.mem_rdata = 32'h0;

        // Reset with both requests raised: nothing may be accepted.
        repeat (3) cyc();
        #2;
        check("rst_iready", bus.imem_ready, 32'd0);
        check("rst_dready", bus.dmem_ready, 32'd0);
        check("rst_mem_req", bus.mem_req, 32'd0);
        check("rst_ivalid", bus.imem_valid, 32'd0);
        check("rst_dvalid", bus.dmem_valid, 32'd0);
        check("rst_irdata", bus.imem_rdata, 32'd0);
        check("rst_drdata", bus.dmem_rdata, 32'd0);
        check("rst_err", bus.mem_err, 32'd0);
        check("rst_addr", bus.mem_addr, 32'd0);
        check("rst_be", bus.mem_be, 32'd0);
        check("rst_we", bus.mem_we, 32'd0);
        check("rst_wdata", bus.mem_wdata, 32'd0);
        cyc(); bus.imem_req = 1'b0; bus.dmem_req = 1'b0; reset = 1'b1;

        // Lone fetch at 0x100, minimum latency.
        cyc(); bus.imem_req = 1'b1; bus.imem_addr = 32'h100; #2;
        check("a_iready", bus.imem_ready, 32'd1);
        check("a_dready", bus.dmem_ready, 32'd0);
        check("a_req_n", bus.mem_req, 32'd0);
        cyc(); bus.imem_req = 1'b0; bus.mem_gnt = 1'b1; #2;
        check("a_req", bus.mem_req, 32'd1);
        check("a_addr", bus.mem_addr, 32'h100);
        check("a_we", bus.mem_we, 32'd0);
        check("a_be", bus.mem_be, 32'hF);
        check("a_iready_busy", bus.imem_ready, 32'd0);
        cyc(); bus.mem_gnt = 1'b0; bus.mem_rvalid = 1'b1; bus.mem_rdata = 32'hDEADBEEF; #2;
        check("a_req_resp", bus.mem_req, 32'd0);
        check("a_ivalid_early", bus.imem_valid, 32'd0);
        cyc(); bus.mem_rvalid = 1'b0; #2;
        check("a_ivalid", bus.imem_valid, 32'd1);
        check("a_irdata", bus.imem_rdata, 32'hDEADBEEF);
        check("a_dvalid", bus.dmem_valid, 32'd0);
        cyc(); #2;
        check("a_ivalid_pulse", bus.imem_valid, 32'd0);

        // Simultaneous data write and fetch: data first, fetch accepted in the valid cycle.
        cyc();
        bus.dmem_req = 1'b1; bus.dmem_we = 1'b1; bus.dmem_be = 4'b0011;
        bus.dmem_addr = 32'h2000; bus.dmem_wdata = 32'h1234;
        bus.imem_req = 1'b1; bus.imem_addr = 32'h300; #2;
        check("b_dready", bus.dmem_ready, 32'd1);
        check("b_iready", bus.imem_ready, 32'd0);
        cyc(); bus.dmem_req = 1'b0; bus.mem_gnt = 1'b1; #2;
        check("b_addr", bus.mem_addr, 32'h2000);
        check("b_we", bus.mem_we, 32'd1);
        check("b_be", bus.mem_be, 32'h3);
        check("b_wdata", bus.mem_wdata, 32'h1234);
        cyc(); bus.mem_gnt = 1'b0; bus.mem_rvalid = 1'b1; bus.mem_rdata = 32'h55;
        cyc(); bus.mem_rvalid = 1'b0; #2;
        check("b_dvalid", bus.dmem_valid, 32'd1);
        check("b_iready_overlap", bus.imem_ready, 32'd1);
        cyc(); bus.imem_req = 1'b0; bus.mem_gnt = 1'b1; #2;
        check("b_faddr", bus.mem_addr, 32'h300);
        check("b_fbe", bus.mem_be, 32'hF);
        check("b_fwe", bus.mem_we, 32'd0);
        cyc(); bus.mem_gnt = 1'b0; bus.mem_rvalid = 1'b1; bus.mem_rdata = 32'hCAFE0001;
        cyc(); bus.mem_rvalid = 1'b0; #2;
        check("b_ivalid", bus.imem_valid, 32'd1);
        check("b_irdata", bus.imem_rdata, 32'hCAFE0001);

        // Grant withheld 3 cycles; stray rvalid in REQ must be ignored.
        cyc();
        bus.dmem_req = 1'b1; bus.dmem_we = 1'b0; bus.dmem_be = 4'hF; bus.dmem_addr = 32'h44; #2;
        check("c_dready", bus.dmem_ready, 32'd1);
        for (int k = 0; k < 3; k++) begin
            cyc();
            bus.dmem_addr = 32'h48; bus.imem_req = 1'b1;
            bus.mem_rvalid = (k == 1); bus.mem_rdata = 32'hBAD0; #2;
            check("c_req", bus.mem_req, 32'd1);
            check("c_addr", bus.mem_addr, 32'h44);
            check("c_be", bus.mem_be, 32'hF);
            check("c_iready", bus.imem_ready, 32'd0);
            check("c_dready_busy", bus.dmem_ready, 32'd0);
            check("c_dvalid", bus.dmem_valid, 32'd0);
        end
        cyc(); bus.mem_rvalid = 1'b0; bus.mem_gnt = 1'b1; #2;
        check("c_req_gnt", bus.mem_req, 32'd1);
        cyc(); bus.mem_gnt = 1'b0; bus.mem_rvalid = 1'b1; bus.mem_rdata = 32'h600D;
        bus.dmem_req = 1'b0; bus.imem_req = 1'b0; #2;
        check("c_req_resp", bus.mem_req, 32'd0);
        cyc(); bus.mem_rvalid = 1'b0; #2;
        check("c_dvalid_done", bus.dmem_valid, 32'd1);
        check("c_drdata", bus.dmem_rdata, 32'h600D);

        // Continuous contention: four data wins, then the fetch, then data again.
        cyc();
        daddr = 32'h1000;
        bus.imem_req = 1'b1; bus.imem_addr = 32'h700;
        bus.dmem_req = 1'b1; bus.dmem_addr = daddr; #2;
        for (int k = 1; k <= 6; k++) begin
            check("d_iready", bus.imem_ready, 32'(k == 5));
            check("d_dready", bus.dmem_ready, 32'(k != 5));
            cyc(); bus.mem_gnt = 1'b1; #2;
            check("d_addr", bus.mem_addr, (k == 5) ? 32'h700 : daddr);
            cyc(); bus.mem_gnt = 1'b0; bus.mem_rvalid = 1'b1; bus.mem_rdata = 32'hA000 + 32'(k);
            cyc(); bus.mem_rvalid = 1'b0;
            if (k != 5) daddr = daddr + 32'd4;
            bus.dmem_addr = daddr;
            if (k == 6) begin bus.imem_req = 1'b0; bus.dmem_req = 1'b0; end
            #2;
            check("d_ivalid", bus.imem_valid, 32'(k == 5));
            check("d_dvalid", bus.dmem_valid, 32'(k != 5));
            check("d_rdata", (k == 5) ? bus.imem_rdata : bus.dmem_rdata, 32'hA000 + 32'(k));
        end

        // Reset while in RESP: transaction dropped, no valid pulse.
        cyc(); bus.dmem_req = 1'b1; bus.dmem_addr = 32'h88; bus.dmem_we = 1'b0; #2;
        check("e_dready", bus.dmem_ready, 32'd1);
        cyc(); bus.dmem_req = 1'b0; bus.mem_gnt = 1'b1;
        cyc(); bus.mem_gnt = 1'b0; reset = 1'b0; bus.mem_rvalid = 1'b1; bus.mem_rdata = 32'hBAD; #2;
        check("e_dready_rst", bus.dmem_ready, 32'd0);
        cyc(); reset = 1'b1; bus.mem_rvalid = 1'b0; #2;
        check("e_dvalid", bus.dmem_valid, 32'd0);
        check("e_req", bus.mem_req, 32'd0);
        cyc(); #2;
        check("e_dvalid2", bus.dmem_valid, 32'd0);
        check("e_drdata", bus.dmem_rdata, 32'd0);
        simple_txn(1'b0, 32'h900, 32'h9009);
        simple_txn(1'b1, 32'h940, 32'h12345678);

`ifdef MEM_ARB_TIMEOUT_EN
        cyc(); bus.dmem_req = 1'b1; bus.dmem_addr = 32'hA0; #2;
        check("t_dready", bus.dmem_ready, 32'd1);
        for (int k = 0; k < TMO; k++) begin
            cyc(); bus.dmem_req = 1'b0; #2;
            check("t_dvalid_wait", bus.dmem_valid, 32'd0);
            check("t_req_wait", bus.mem_req, 32'd1);
        end
        cyc(); #2;
        check("t_dvalid", bus.dmem_valid, 32'd1);
        check("t_drdata", bus.dmem_rdata, 32'd0);
        check("t_err", bus.mem_err, 32'd1);
        check("t_req_idle", bus.mem_req, 32'd0);
        simple_txn(1'b0, 32'hB00, 32'h0B00);
        check("t_err_sticky", bus.mem_err, 32'd1);
        cyc(); reset = 1'b0;
        cyc(); reset = 1'b1; #2;
        check("t_err_clr", bus.mem_err, 32'd0);
`else
        cyc(); bus.dmem_req = 1'b1; bus.dmem_addr = 32'hA0; #2;
        check("t_dready", bus.dmem_ready, 32'd1);
        cyc(); bus.dmem_req = 1'b0; bus.mem_gnt = 1'b1;
        for (int k = 0; k < 20; k++) begin
            cyc(); bus.mem_gnt = 1'b0; #2;
            check("t_dvalid_wait", bus.dmem_valid, 32'd0);
            check("t_err", bus.mem_err, 32'd0);
        end
        cyc(); bus.mem_rvalid = 1'b1; bus.mem_rdata = 32'h77;
        cyc(); bus.mem_rvalid = 1'b0; #2;
        check("t_dvalid", bus.dmem_valid, 32'd1);
        check("t_drdata", bus.dmem_rdata, 32'h77);
`endif

        // Randomized traffic against the transaction-level reference model.
        m_busy = 0; m_granted = 0; m_starve = 0; m_wait = 0;
        m_exp_vi = 0; m_exp_vd = 0; ip = 0; dp = 0; gi_prev = 0; exp_gd = 0;
        for (int c = 0; c < 800; c++) begin
            cyc();
            if (!ip || gi_prev) begin
                ip = ($urandom_range(0, 3) != 0);
                bus.imem_addr = $urandom & 32'hFFFF_FFFC;
            end
            if (!dp || exp_gd) begin
                dp = ($urandom_range(0, 3) != 0);
                bus.dmem_addr  = $urandom & 32'hFFFF_FFFC;
                bus.dmem_we    = 1'($urandom_range(0, 1));
                bus.dmem_be    = 4'($urandom_range(1, 15));
                bus.dmem_wdata = $urandom;
            end
            bus.imem_req = ip;
            bus.dmem_req = dp;
            bus.mem_gnt  = m_busy && !m_granted && (m_wait >= 3 || $urandom_range(0, 1) == 1);
            bus.mem_rvalid = (m_busy && m_granted) ? (m_wait >= 3 || $urandom_range(0, 1) == 1)
                                                   : ($urandom_range(0, 7) == 0);
            bus.mem_rdata = $urandom;
            #2;
            exp_gi = !m_busy && ip && (!dp || m_starve == LIMIT);
            exp_gd = !m_busy && dp && !exp_gi;
            check("r_iready", bus.imem_ready, 32'(exp_gi));
            check("r_dready", bus.dmem_ready, 32'(exp_gd));
            check("r_req", bus.mem_req, 32'(m_busy && !m_granted));
            if (m_busy && !m_granted) begin
                check("r_addr", bus.mem_addr, m_addr);
                check("r_we", bus.mem_we, 32'(m_we));
                check("r_be", bus.mem_be, 32'(m_be));
                if (m_we) check("r_wdata", bus.mem_wdata, m_wdata);
            end
            check("r_ivalid", bus.imem_valid, 32'(m_exp_vi));
            check("r_dvalid", bus.dmem_valid, 32'(m_exp_vd));
            if (m_exp_vi) check("r_irdata", bus.imem_rdata, m_exp_irdata);
            if (m_exp_vd) check("r_drdata", bus.dmem_rdata, m_exp_drdata);

            m_exp_vi = 0;
            m_exp_vd = 0;
            if (m_busy) begin
                if (m_granted && bus.mem_rvalid) begin
                    m_busy = 0;
                    if (m_own_d) begin m_exp_vd = 1; m_exp_drdata = bus.mem_rdata; end
                    else         begin m_exp_vi = 1; m_exp_irdata = bus.mem_rdata; end
                end else if (!m_granted && bus.mem_gnt) begin
                    m_granted = 1; m_wait = 0;
                end else begin
                    m_wait++;
                end
            end else if (exp_gi || exp_gd) begin
                m_busy = 1; m_granted = 0; m_wait = 0; m_own_d = exp_gd;
                m_addr  = exp_gd ? bus.dmem_addr : bus.imem_addr;
                m_we    = exp_gd ? bus.dmem_we : 1'b0;
                m_be    = exp_gd ? bus.dmem_be : 4'hF;
                m_wdata = bus.dmem_wdata;
            end
            if (!ip || exp_gi) m_starve = 0;
            else if (exp_gd && m_starve < LIMIT) m_starve++;
            gi_prev = exp_gi;
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
